am386sx_bus_responder: RTL and testbench
========================================

AM386SX_BUS_RESPONDER -- requirements
Module: am386sx_bus_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, 24'h000000, byte-address base of the decoded window.
REQ-002 SHALL have parameter ADDR_MASK, 24'hFF0000, a window hit is (addr & ADDR_MASK) == BASE_ADDR.
REQ-003 SHALL have parameter MIN_WAIT, 1, minimum number of wait states inserted before READY#.
REQ-004 SHALL have parameter TIMEOUT, 255, number of cycles to wait for backend ack before forcing completion.
REQ-005 SHALL have port SYS_CLK, input, 1, the single clock; every flop is rising-edge SYS_CLK.
REQ-006 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port cpu_ads_n, input, 1, address strobe, already synchronized to SYS_CLK.
REQ-008 SHALL have ports cpu_mio_n, cpu_dc_n and cpu_wr_n, input, 1 each, cycle definition.
REQ-009 SHALL have ports cpu_bhe_n and cpu_ble_n, input, 1 each, byte enables.
REQ-010 SHALL have ports cpu_addr, input, 23 (A23:A1), and cpu_data_i, input, 16, write data.
REQ-011 SHALL have ports cpu_ready_n, output, 1; cpu_data_o, output, 16; cpu_data_oe, output, 1, read drive enable.
REQ-012 SHALL have backend outputs bus_req, bus_we, bus_io (1 each), bus_addr (24), bus_be (2) and bus_wdata (16).
REQ-013 SHALL have backend inputs bus_ack (1) and bus_rdata (16), plus output err_timeout (1), a one-cycle pulse.

Function
REQ-014 SHALL implement the FSM IDLE -> WAIT -> DONE -> IDLE, plus the path IDLE -> DONE for special cycles.
REQ-015 In IDLE, cpu_ads_n==0 with cpu_dc_n==1 and a window hit SHALL latch address, byte enables, M/IO#, W/R# and write data, then move to WAIT.
REQ-016 The latched bus_addr SHALL be {cpu_addr,1'b0}; bus_be SHALL be {~bhe_n,~ble_n}; bus_io SHALL be ~mio_n.
REQ-017 In IDLE, cpu_ads_n==0 with cpu_dc_n==0 and cpu_wr_n==1 (halt/shutdown) SHALL go directly to DONE with no bus_req.
REQ-018 Cycles that miss the window, and interrupt-acknowledge cycles (dc_n=0, wr_n=0), SHALL be ignored; the FSM stays in IDLE and cpu_ready_n stays 1.
REQ-019 In WAIT, bus_req SHALL be 1 and held stable with all bus_* fields until the first cycle bus_ack==1.
REQ-020 The transition from WAIT to DONE SHALL occur only once bus_ack has been seen AND at least MIN_WAIT cycles have elapsed in WAIT; an ack arriving before MIN_WAIT expires SHALL be remembered.
REQ-021 For reads, bus_rdata SHALL be captured on the ack cycle.
REQ-022 bus_req SHALL drop in the cycle after ack, and SHALL never be reasserted for the same CPU cycle.
REQ-023 If no ack arrives within TIMEOUT cycles in WAIT, the FSM SHALL go to DONE with read data 16'hFFFF and pulse err_timeout for 1 cycle.
REQ-024 The FSM SHALL then ignore any late ack.
REQ-025 DONE SHALL last exactly 1 cycle with cpu_ready_n=0; cpu_ready_n SHALL be 1 in every other state.
REQ-026 cpu_data_oe SHALL be 1 from the cycle after ack/timeout through DONE, for reads only; otherwise 0.
REQ-027 cpu_data_o SHALL hold the captured data while cpu_data_oe==1.
REQ-028 A cpu_ads_n==0 sample in WAIT or DONE SHALL be ignored; pipelined addressing is not supported.
REQ-029 Latency: with an immediate ack and MIN_WAIT=1, READY# SHALL assert 2 cycles after the ADS# sample cycle.

Reset
REQ-030 Reset SHALL force IDLE and bus_req=0, cpu_ready_n=1, cpu_data_oe=0, cpu_data_o=0, err_timeout=0, all latched fields =0, and both counters =0.
REQ-031 Reset asserted mid-cycle SHALL abandon the transaction within the same edge, with no READY# and no err_timeout.

Structure
REQ-032 The FSM state enum and the cycle-definition encodings (MEM_RD, MEM_WR, IO_RD, IO_WR, HALT, INTA) SHALL live in shared package am386sx_pkg.
REQ-033 The wait/timeout counter SHALL be one sub-module, am386sx_wait_ctr (load, enable, terminal flags).

Verification
REQ-034 Memory read at 0x001234, BE=11, ack on the 3rd WAIT cycle with rdata=16'hBEEF -> bus_addr=0x001234, then 1 cycle of ready_n=0 with data_o=BEEF and data_oe=1.
REQ-035 I/O write to 0x0080 with ble_n=0, bhe_n=1, data 0x00A5 -> bus_io=1, bus_we=1, be=01, wdata=00A5, data_oe stays 0.
REQ-036 Address 0x100000 (miss) -> no bus_req and ready_n stays 1 for 20 cycles.
REQ-037 Read with no ack and TIMEOUT=8 -> ready_n pulses after 8 WAIT cycles with data 0xFFFF and err_timeout pulse; a late ack is ignored.
REQ-038 Halt cycle -> ready_n=0 for 1 cycle, no bus_req.
REQ-039 Reset asserted during WAIT -> next cycle IDLE, bus_req=0, no READY#; the next valid ADS# is served normally.

Source files
------------

// File: rtl/am386sx_pkg.sv
// Shared types for the Am386SX bus responder: FSM states and
// cycle-definition codes built from {M/IO#, D/C#, W/R#}.
package am386sx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    INTA   = 3'b000,
    HALT   = 3'b001,
    IO_WR  = 3'b010,
    IO_RD  = 3'b011,
    MEM_WR = 3'b110,
    MEM_RD = 3'b111
  } cyc_t;

  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

  // Special cycles ignore M/IO#, so the two D/C#=0 codes fold together.
  function automatic cyc_t cyc_decode(
    input logic mio_n,
    input logic dc_n,
    input logic wr_n
  );
    cyc_t c;
    unique case ({dc_n, wr_n})
      2'b00:   c = INTA;
      2'b01:   c = HALT;
      2'b10:   c = mio_n ? MEM_WR : IO_WR;
      default: c = mio_n ? MEM_RD : IO_RD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/am386sx_wait_ctr.sv
// Saturating WAIT-state counter with minimum-wait and timeout
// terminal flags, both valid for the cycle currently being counted.
module am386sx_wait_ctr #(
  parameter int W     = 9,
  parameter int MIN_T = 1,
  parameter int MAX_T = 255
) (
  input  logic SYS_CLK,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic min_hit,
  output logic max_hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge SYS_CLK) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (en && (int'(cnt) < MAX_T)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds completed cycles; +1 counts the one in progress.
  assign min_hit = (int'(cnt) + 1) >= MIN_T;
  assign max_hit = (int'(cnt) + 1) >= MAX_T;

endmodule

// File: rtl/am386sx_bus_responder.sv
// Am386SX local-bus slave: decodes one address window and bridges
// CPU cycles to a req/ack backend with wait-state and timeout control.
module am386sx_bus_responder
  import am386sx_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter logic [23:0] ADDR_MASK = 24'hFF0000,
  parameter int          MIN_WAIT  = 1,
  parameter int          TIMEOUT   = 255
) (
  input  logic        SYS_CLK,
  input  logic        reset,
  input  logic        cpu_ads_n,
  input  logic        cpu_mio_n,
  input  logic        cpu_dc_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_bhe_n,
  input  logic        cpu_ble_n,
  input  logic [22:0] cpu_addr,
  input  logic [15:0] cpu_data_i,
  output logic        cpu_ready_n,
  output logic [15:0] cpu_data_o,
  output logic        cpu_data_oe,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [23:0] bus_addr,
  output logic [1:0]  bus_be,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT + MIN_WAIT + 2);

  state_t state;
  cyc_t   cyc;
  logic   hit;
  logic   ack_seen;
  logic   got_ack;
  logic   ctr_load;
  logic   ctr_en;
  logic   min_hit;
  logic   max_hit;

  assign cyc      = cyc_decode(cpu_mio_n, cpu_dc_n, cpu_wr_n);
  assign hit      = ({cpu_addr, 1'b0} & ADDR_MASK) == BASE_ADDR;
  assign got_ack  = ack_seen | bus_ack;
  assign ctr_load = (state == S_IDLE);
  assign ctr_en   = (state == S_WAIT);

  am386sx_wait_ctr #(
    .W    (CW),
    .MIN_T(MIN_WAIT),
    .MAX_T(TIMEOUT)
  ) u_wait_ctr (
    .SYS_CLK(SYS_CLK),
    .reset  (reset),
    .load   (ctr_load),
    .en     (ctr_en),
    .min_hit(min_hit),
    .max_hit(max_hit)
  );

  always_ff @(posedge SYS_CLK) begin
    if (reset) begin
      state       <= S_IDLE;
      ack_seen    <= 1'b0;
      cpu_ready_n <= 1'b1;
      cpu_data_o  <= '0;
      cpu_data_oe <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_io      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!cpu_ads_n) begin
            unique case (cyc)
              HALT: begin
                state       <= S_DONE;
                cpu_ready_n <= 1'b0;
              end
              MEM_RD, MEM_WR, IO_RD, IO_WR: begin
                if (hit) begin
                  state     <= S_WAIT;
                  ack_seen  <= 1'b0;
                  bus_req   <= 1'b1;
                  bus_we    <= ~cpu_wr_n;
                  bus_io    <= ~cpu_mio_n;
                  bus_addr  <= {cpu_addr, 1'b0};
                  bus_be    <= {~cpu_bhe_n, ~cpu_ble_n};
                  bus_wdata <= cpu_data_i;
                end
              end
              default: ;
            endcase
          end
        end
        S_WAIT: begin
          if (bus_ack && !ack_seen) begin
            ack_seen    <= 1'b1;
            bus_req     <= 1'b0;
            cpu_data_oe <= ~bus_we;
            if (!bus_we) cpu_data_o <= bus_rdata;
          end
          if (got_ack && min_hit) begin
            state       <= S_DONE;
            cpu_ready_n <= 1'b0;
          end else if (!got_ack && max_hit) begin
            state       <= S_DONE;
            cpu_ready_n <= 1'b0;
            bus_req     <= 1'b0;
            err_timeout <= 1'b1;
            cpu_data_oe <= ~bus_we;
            if (!bus_we) cpu_data_o <= TIMEOUT_DATA;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          cpu_ready_n <= 1'b1;
          cpu_data_oe <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_am386sx_bus_responder.sv
// Randomized bench for am386sx_bus_responder against a per-transaction
// timeline model (request window, ready cycle, drive window).
module tb_am386sx_bus_responder;

  localparam int MINW = 3;
  localparam int TMO  = 8;
  localparam int NCYC = 20;

  logic        SYS_CLK = 1'b0;
  logic        reset   = 1'b1;
  logic        cpu_ads_n = 1'b1;
  logic        cpu_mio_n = 1'b1;
  logic        cpu_dc_n  = 1'b1;
  logic        cpu_wr_n  = 1'b1;
  logic        cpu_bhe_n = 1'b1;
  logic        cpu_ble_n = 1'b1;
  logic [22:0] cpu_addr  = '0;
  logic [15:0] cpu_data_i = '0;
  logic        bus_ack   = 1'b0;
  logic [15:0] bus_rdata = '0;
  logic        cpu_ready_n;
  logic [15:0] cpu_data_o;
  logic        cpu_data_oe;
  logic        bus_req;
  logic        bus_we;
  logic        bus_io;
  logic [23:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wdata;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  am386sx_bus_responder #(
    .BASE_ADDR(24'h000000),
    .ADDR_MASK(24'hFF0000),
    .MIN_WAIT (MINW),
    .TIMEOUT  (TMO)
  ) dut (
    .SYS_CLK    (SYS_CLK),
    .reset      (reset),
    .cpu_ads_n  (cpu_ads_n),
    .cpu_mio_n  (cpu_mio_n),
    .cpu_dc_n   (cpu_dc_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_bhe_n  (cpu_bhe_n),
    .cpu_ble_n  (cpu_ble_n),
    .cpu_addr   (cpu_addr),
    .cpu_data_i (cpu_data_i),
    .cpu_ready_n(cpu_ready_n),
    .cpu_data_o (cpu_data_o),
    .cpu_data_oe(cpu_data_oe),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_io     (bus_io),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 32'(cpu_ready_n), 32'd1);
    chk({tag, "_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_oe"}, 32'(cpu_data_oe), 32'd0);
    chk({tag, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  task automatic chk_cleared(input string tag);
    chk_idle(tag);
    chk({tag, "_dout"}, 32'(cpu_data_o), 32'd0);
    chk({tag, "_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_be"}, 32'(bus_be), 32'd0);
    chk({tag, "_wd"}, 32'(bus_wdata), 32'd0);
  endtask

  // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 halt, 5 inta
  // a: WAIT cycle (1-based) on which the backend pulses ack
  task automatic run_txn(input int kind, input logic [22:0] addr,
                         input logic [1:0] be, input logic [15:0] wd,
                         input int a, input logic [15:0] rd);
    logic [23:0] byte_addr;
    bit is_io, is_wr, served, acked, tmo, exp_req, exp_oe;
    int r, req_end, oe_lo;
    byte_addr = {addr, 1'b0};
    is_io  = (kind == 2) || (kind == 3);
    is_wr  = (kind == 1) || (kind == 3);
    served = (kind < 4) && (byte_addr < 24'h010000);
    acked  = served && (a >= 1) && (a <= TMO);
    tmo    = served && !acked;
    if (kind == 4) r = 1;
    else if (acked) r = ((a > MINW) ? a : MINW) + 1;
    else if (served) r = TMO + 1;
    else r = 0;
    req_end = acked ? a : (served ? TMO : 0);
    oe_lo   = acked ? a + 1 : r;

    @(posedge SYS_CLK); #1;
    cpu_ads_n  = 1'b0;
    cpu_dc_n   = (kind < 4);
    cpu_mio_n  = (kind >= 4) ? 1'($urandom_range(0, 1)) : !is_io;
    cpu_wr_n   = (kind == 4) ? 1'b1 : (kind == 5) ? 1'b0 : !is_wr;
    cpu_bhe_n  = ~be[1];
    cpu_ble_n  = ~be[0];
    cpu_addr   = addr;
    cpu_data_i = wd;
    bus_ack    = 1'b0;
    bus_rdata  = 16'($urandom);
    @(negedge SYS_CLK);
    chk_idle("c0");

    for (int c = 1; c <= NCYC; c++) begin
      @(posedge SYS_CLK); #1;
      cpu_ads_n  = (c < r && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      cpu_addr   = 23'($urandom);
      cpu_data_i = 16'($urandom);
      cpu_mio_n  = 1'($urandom_range(0, 1));
      cpu_dc_n   = 1'b1;
      cpu_wr_n   = 1'($urandom_range(0, 1));
      bus_ack    = (c == a);
      bus_rdata  = (c == a) ? rd : 16'($urandom);
      @(negedge SYS_CLK);
      exp_req = (c <= req_end);
      exp_oe  = served && !is_wr && (c >= oe_lo) && (c <= r);
      chk("req", 32'(bus_req), 32'(exp_req));
      chk("rdy", 32'(cpu_ready_n), 32'(c != r));
      chk("oe", 32'(cpu_data_oe), 32'(exp_oe));
      chk("err", 32'(err_timeout), 32'(tmo && (c == r)));
      if (exp_req) begin
        chk("addr", 32'(bus_addr), 32'(byte_addr));
        chk("be", 32'(bus_be), 32'(be));
        chk("we", 32'(bus_we), 32'(is_wr));
        chk("io", 32'(bus_io), 32'(is_io));
        chk("wd", 32'(bus_wdata), 32'(wd));
      end
      if (exp_oe) chk("dout", 32'(cpu_data_o), 32'(acked ? rd : 16'hFFFF));
    end
    cpu_ads_n = 1'b1;
    bus_ack   = 1'b0;
  endtask

  task automatic reset_mid();
    @(posedge SYS_CLK); #1;
    cpu_ads_n = 1'b0;
    cpu_mio_n = 1'b1;
    cpu_dc_n  = 1'b1;
    cpu_wr_n  = 1'b1;
    cpu_bhe_n = 1'b0;
    cpu_ble_n = 1'b0;
    cpu_addr  = 23'h000200;
    bus_ack   = 1'b0;
    @(posedge SYS_CLK); #1;
    cpu_ads_n = 1'b1;
    @(negedge SYS_CLK);
    chk("rst_pre_req", 32'(bus_req), 32'd1);
    @(posedge SYS_CLK); #1;
    reset = 1'b1;
    @(posedge SYS_CLK); #1;
    reset   = 1'b0;
    bus_ack = 1'b1;
    @(negedge SYS_CLK);
    chk_cleared("rst_mid");
    for (int i = 0; i < 4; i++) begin
      @(posedge SYS_CLK); #1;
      bus_ack = 1'b0;
      @(negedge SYS_CLK);
      chk_idle("rst_after");
    end
  endtask

  initial begin
    repeat (3) @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    chk_cleared("rst");
    @(posedge SYS_CLK); #1;
    reset = 1'b0;

    run_txn(0, 23'h00091A, 2'b11, 16'h0000, 3, 16'hBEEF);
    run_txn(3, 23'h000040, 2'b01, 16'h00A5, 1, 16'h0000);
    run_txn(0, 23'h080000, 2'b11, 16'h0000, 2, 16'h1111);
    run_txn(0, 23'h000100, 2'b11, 16'h0000, TMO + 1, 16'h1234);
    run_txn(4, 23'h000000, 2'b00, 16'h0000, 0, 16'h0000);
    run_txn(5, 23'h000010, 2'b11, 16'h0000, 1, 16'h0000);
    run_txn(1, 23'h007FFF, 2'b10, 16'h5A5A, TMO, 16'h0000);
    reset_mid();
    run_txn(2, 23'h000300, 2'b11, 16'h0000, 1, 16'hC0DE);

    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [22:0] addr;
      kind = $urandom_range(0, 5);
      if ($urandom_range(0, 3) != 0) addr = 23'($urandom_range(0, 16'h7FFF));
      else addr = 23'($urandom_range(23'h008000, 23'h7FFFFF));
      run_txn(kind, addr, 2'($urandom), 16'($urandom),
              $urandom_range(1, TMO + 2), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
